count_sequencer: RTL and testbench

Initiator for the progressive-count handshake. It drives `initSignal` to launch the 0→15 counter block and watches its `finalSignal` and `suma` outputs. It then drives `initSignal` again to return the counter to idle. It repeats this for a requested number of runs and flags protocol violations. It runs on the undivided system clock and sits between the front-panel control logic and the counter block.

---
 rtl/count_sequencer_if.sv | 26 ++
 rtl/count_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_count_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/count_sequencer_if.sv
// Handshake bundle between the count sequencer, the front-panel control
// logic and the 0..15 progressive counter block.
interface count_sequencer_if;
    logic       start;
    logic [3:0] runs;
    logic       initSignal;
    logic       finalSignal;
    logic [3:0] suma;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    logic [3:0] runs_done;

    // Sequencer side: drives the counter launch and reports status.
    modport master (
        input  start, runs, finalSignal, suma,
        output initSignal, busy, done, error, err_code, runs_done
    );

    // Environment side: front panel plus counter block.
    modport slave (
        output start, runs, finalSignal, suma,
        input  initSignal, busy, done, error, err_code, runs_done
    );
endinterface

// File: rtl/count_sequencer.sv
// Initiator for the progressive-count handshake. Launches the counter with
// a held initSignal pulse, checks that suma climbs monotonically to 15 with
// finalSignal, releases the counter with a second pulse, and repeats for the
// requested number of runs. Protocol violations end the sequence with a
// sticky error and a code.
module count_sequencer #(
    parameter int HOLD_CYCLES = 64,
    parameter int TIMEOUT     = 65535
) (
    input  logic                clk,
    input  logic                reset,
    count_sequencer_if.master   bus
);
    localparam int              HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [15:0]     TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [15:0]     TMO_MAX   = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LAUNCH   = 3'd1,
        S_WAIT_FIN = 3'd2,
        S_RELEASE  = 3'd3,
        S_WAIT_CLR = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    state_t            state_r, state_next;
    logic [HOLD_W-1:0] hold_r, hold_next;
    logic [15:0]       tmo_r, tmo_next;
    logic [3:0]        prev_r, prev_next;
    logic [3:0]        runs_lat_r, runs_lat_next;
    logic [3:0]        runs_done_r, runs_done_next;
    logic              init_r, init_next;
    logic              busy_r, busy_next;
    logic              done_r, done_next;
    logic              error_r, error_next;
    logic [1:0]        err_code_r, err_code_next;
    logic              fault_s;
    logic [1:0]        fault_code_s;

    // State and datapath registers; reset has priority over everything, including start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            hold_r      <= '0;
            tmo_r       <= 16'd0;
            prev_r      <= 4'd0;
            runs_lat_r  <= 4'd1;
            runs_done_r <= 4'd0;
            init_r      <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            err_code_r  <= 2'd0;
        end else begin
            state_r     <= state_next;
            hold_r      <= hold_next;
            tmo_r       <= tmo_next;
            prev_r      <= prev_next;
            runs_lat_r  <= runs_lat_next;
            runs_done_r <= runs_done_next;
            init_r      <= init_next;
            busy_r      <= busy_next;
            done_r      <= done_next;
            error_r     <= error_next;
            err_code_r  <= err_code_next;
        end
    end

    // Next-state and next-output decode; a detected fault overrides whatever the state chose.
    always_comb begin
        state_next     = state_r;
        hold_next      = hold_r;
        tmo_next       = tmo_r;
        prev_next      = prev_r;
        runs_lat_next  = runs_lat_r;
        runs_done_next = runs_done_r;
        init_next      = 1'b0;
        busy_next      = busy_r;
        done_next      = 1'b0;
        error_next     = error_r;
        err_code_next  = err_code_r;
        fault_s        = 1'b0;
        fault_code_s   = 2'd0;

        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    runs_lat_next  = (bus.runs == 4'd0) ? 4'd1 : bus.runs;
                    runs_done_next = 4'd0;
                    error_next     = 1'b0;
                    err_code_next  = 2'd0;
                    busy_next      = 1'b1;
                    init_next      = 1'b1;
                    hold_next      = '0;
                    state_next     = S_LAUNCH;
                end else begin
                    busy_next = 1'b0;
                end
            end

            S_LAUNCH, S_RELEASE: begin
                init_next = 1'b1;
                if (hold_r == HOLD_LAST) begin
                    // Pulse complete: fresh timeout window and monotonic baseline.
                    init_next  = 1'b0;
                    tmo_next   = 16'd0;
                    prev_next  = 4'd0;
                    state_next = (state_r == S_LAUNCH) ? S_WAIT_FIN : S_WAIT_CLR;
                end else begin
                    hold_next = hold_r + HOLD_W'(1);
                end
            end

            S_WAIT_FIN: begin
                prev_next = bus.suma;
                if ((bus.suma != prev_r) && (bus.suma != (prev_r + 4'd1))) begin
                    fault_s      = 1'b1;
                    fault_code_s = 2'd2;
                end else if (bus.finalSignal) begin
                    // finalSignal is evaluated ahead of the timeout so it wins a tie.
                    if (bus.suma == 4'd15) begin
                        init_next  = 1'b1;
                        hold_next  = '0;
                        state_next = S_RELEASE;
                    end else begin
                        fault_s      = 1'b1;
                        fault_code_s = 2'd3;
                    end
                end else if (tmo_r >= TMO_LAST) begin
                    fault_s      = 1'b1;
                    fault_code_s = 2'd1;
                end else begin
                    tmo_next = (tmo_r == TMO_MAX) ? tmo_r : (tmo_r + 16'd1);
                end
            end

            S_WAIT_CLR: begin
                if (!bus.finalSignal) begin
                    runs_done_next = runs_done_r + 4'd1;
                    if (runs_done_next == runs_lat_r) begin
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        state_next = S_IDLE;
                    end else begin
                        init_next  = 1'b1;
                        hold_next  = '0;
                        state_next = S_LAUNCH;
                    end
                end else if (tmo_r >= TMO_LAST) begin
                    fault_s      = 1'b1;
                    fault_code_s = 2'd1;
                end else begin
                    tmo_next = (tmo_r == TMO_MAX) ? tmo_r : (tmo_r + 16'd1);
                end
            end

            S_FAULT: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
                busy_next  = 1'b0;
            end
        endcase

        state_next    = fault_s ? S_FAULT : state_next;
        error_next    = error_next | fault_s;
        err_code_next = fault_s ? fault_code_s : err_code_next;
        busy_next     = busy_next & ~fault_s;
        init_next     = init_next & ~fault_s;
    end

    // initSignal is gated by reset so the counter sees the drop without waiting for an edge.
    assign bus.initSignal = init_r & ~reset;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.error      = error_r;
    assign bus.err_code   = err_code_r;
    assign bus.runs_done  = runs_done_r;
endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: a behavioural 0..15 counter
// answers the handshake, a table of scenarios checks end-of-sequence status,
// and hand-written sequences check cycle-exact timing corners.
module tb_count_sequencer;
    localparam int HOLD = 64;
    localparam int TMO  = 1000;
    localparam int M_NORMAL = 0;
    localparam int M_STALL  = 1;
    localparam int M_SKIP   = 2;
    localparam int M_EARLY  = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   mode = M_NORMAL;

    count_sequencer_if bus();

    count_sequencer #(.HOLD_CYCLES(HOLD), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural counter block, updated on the falling edge.
    int cst = 0;
    int div = 0;
    always @(negedge clk) begin
        if (reset) begin
            cst = 0; div = 0; bus.suma = 4'd0; bus.finalSignal = 1'b0;
        end else begin
            case (cst)
                0: begin
                    bus.suma = 4'd0; bus.finalSignal = 1'b0;
                    if (bus.initSignal === 1'b1) cst = 1;
                end
                1: if (bus.initSignal === 1'b0) begin cst = 2; div = 0; end
                2: begin
                    div++;
                    if (div == 8) begin
                        div = 0;
                        if (mode == M_EARLY && bus.suma == 4'd12) begin
                            bus.finalSignal = 1'b1; cst = 3;
                        end else if (bus.suma == 4'd15) begin
                            bus.finalSignal = 1'b1; cst = 3;
                        end else if (mode == M_STALL && bus.suma == 4'd7) begin
                            bus.suma = 4'd7;
                        end else if (mode == M_SKIP && bus.suma == 4'd4) begin
                            bus.suma = 4'd6;
                        end else begin
                            bus.suma = bus.suma + 4'd1;
                        end
                    end
                end
                3: if (bus.initSignal === 1'b1) cst = 4;
                4: if (bus.initSignal === 1'b0) begin
                    bus.finalSignal = 1'b0; bus.suma = 4'd0; cst = 0;
                end
                default: cst = 0;
            endcase
        end
    end

    // Output monitor: running totals that scenarios difference.
    int done_total = 0, pulse_total = 0, bad_len_total = 0;
    int busy_fall_total = 0, rd_step_total = 0, cur_len = 0;
    logic prev_busy = 1'b0;
    logic [3:0] prev_rd = 4'd0;
    always @(negedge clk) begin
        if (bus.done === 1'b1) done_total++;
        if (bus.initSignal === 1'b1) cur_len++;
        else if (cur_len != 0) begin
            pulse_total++;
            if (cur_len != HOLD) bad_len_total++;
            cur_len = 0;
        end
        if (prev_busy === 1'b1 && bus.busy === 1'b0) busy_fall_total++;
        if (bus.runs_done === (prev_rd + 4'd1)) rd_step_total++;
        prev_busy = bus.busy;
        prev_rd   = bus.runs_done;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (bus.busy !== 1'b0 && n < limit) begin
            @(negedge clk); n++;
        end
        check("busy_timeout", 32'(n < limit), 32'd1);
    endtask

    task automatic wait_init(input logic lvl, input int limit);
        int n = 0;
        while (bus.initSignal !== lvl && n < limit) begin
            @(negedge clk); n++;
        end
        check("init_wait_timeout", 32'(n < limit), 32'd1);
    endtask

    task automatic pulse_start(input logic [3:0] r);
        bus.runs = r; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    typedef struct {
        int         m;
        logic [3:0] runs;
        logic       exp_error;
        logic [1:0] exp_code;
        logic [3:0] exp_rd;
        int         exp_done;
        int         exp_pulses;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int d0, p0, b0, f0, s0;
        bus.start = 1'b0; bus.runs = 4'd0;

        vecs[0] = '{M_NORMAL, 4'd1, 1'b0, 2'd0, 4'd1, 1, 2};
        vecs[1] = '{M_NORMAL, 4'd3, 1'b0, 2'd0, 4'd3, 1, 6};
        vecs[2] = '{M_NORMAL, 4'd0, 1'b0, 2'd0, 4'd1, 1, 2};
        vecs[3] = '{M_STALL,  4'd2, 1'b1, 2'd1, 4'd0, 0, 1};
        vecs[4] = '{M_SKIP,   4'd1, 1'b1, 2'd2, 4'd0, 0, 1};
        vecs[5] = '{M_EARLY,  4'd1, 1'b1, 2'd3, 4'd0, 0, 1};

        // Reset state
        do_reset();
        check("reset_outputs", 32'({bus.initSignal, bus.busy, bus.done, bus.error,
                                    bus.err_code, bus.runs_done}), 32'd0);

        // Table-driven scenarios
        for (int i = 0; i < 6; i++) begin
            do_reset();
            mode = vecs[i].m;
            d0 = done_total; p0 = pulse_total; b0 = bad_len_total;
            f0 = busy_fall_total; s0 = rd_step_total;
            pulse_start(vecs[i].runs);
            wait_idle(4000);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_error", i), 32'(bus.error), 32'(vecs[i].exp_error));
            check($sformatf("v%0d_err_code", i), 32'(bus.err_code), 32'(vecs[i].exp_code));
            check($sformatf("v%0d_runs_done", i), 32'(bus.runs_done), 32'(vecs[i].exp_rd));
            check($sformatf("v%0d_done_pulses", i), 32'(done_total - d0), 32'(vecs[i].exp_done));
            check($sformatf("v%0d_init_pulses", i), 32'(pulse_total - p0), 32'(vecs[i].exp_pulses));
            check($sformatf("v%0d_bad_pulse_len", i), 32'(bad_len_total - b0), 32'd0);
            check($sformatf("v%0d_busy_falls", i), 32'(busy_fall_total - f0), 32'd1);
            check($sformatf("v%0d_rd_steps", i), 32'(rd_step_total - s0), 32'(vecs[i].exp_rd));
        end

        // Launch timing: initSignal/busy from the cycle after start, held exactly HOLD cycles
        do_reset();
        mode = M_NORMAL;
        pulse_start(4'd1);
        check("launch_first_cycle", 32'({bus.initSignal, bus.busy}), 32'd3);
        repeat (HOLD - 1) @(negedge clk);
        check("launch_last_cycle", 32'(bus.initSignal), 32'd1);
        @(negedge clk);
        check("launch_drop", 32'(bus.initSignal), 32'd0);
        d0 = done_total;
        wait_idle(2000);
        @(negedge clk);
        check("launch_done_once", 32'(done_total - d0), 32'd1);

        // Skip: fault visible one cycle after suma=6 is presented
        do_reset();
        mode = M_SKIP;
        pulse_start(4'd1);
        begin
            int n = 0;
            while (n < 400) begin
                @(negedge clk); #1; n++;
                if (bus.suma == 4'd6) break;
            end
            check("skip_seen", 32'(bus.suma), 32'd6);
            check("skip_not_yet", 32'(bus.error), 32'd0);
        end
        @(negedge clk);
        check("skip_fault", 32'({bus.error, bus.err_code, bus.busy, bus.initSignal}), 32'b1_10_0_0);

        // Stall: timeout exactly TMO cycles into WAIT_FIN
        do_reset();
        mode = M_STALL;
        pulse_start(4'd1);
        wait_init(1'b0, 200);
        repeat (TMO - 1) @(negedge clk);
        check("stall_before_timeout", 32'(bus.error), 32'd0);
        @(negedge clk);
        check("stall_timeout", 32'({bus.error, bus.err_code, bus.initSignal, bus.busy}), 32'b1_01_0_0);

        // start together with reset is ignored
        reset = 1'b1; bus.start = 1'b1; bus.runs = 4'd1;
        @(negedge clk);
        reset = 1'b0; bus.start = 1'b0;
        @(negedge clk);
        check("start_with_reset", 32'({bus.busy, bus.initSignal}), 32'd0);

        // Reset at hold cycle 30 of RELEASE, then a runs=0 sequence
        do_reset();
        mode = M_NORMAL;
        pulse_start(4'd1);
        wait_init(1'b0, 200);
        wait_init(1'b1, 400);
        repeat (29) @(negedge clk);
        check("release_active", 32'(bus.initSignal), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_init_immediate", 32'(bus.initSignal), 32'd0);
        @(negedge clk);
        check("reset_mid_release", 32'({bus.initSignal, bus.busy, bus.done, bus.error,
                                        bus.err_code, bus.runs_done}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        d0 = done_total;
        pulse_start(4'd0);
        wait_idle(2000);
        @(negedge clk);
        check("after_reset_done", 32'(done_total - d0), 32'd1);
        check("after_reset_runs_done", 32'(bus.runs_done), 32'd1);
        check("after_reset_error", 32'(bus.error), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
